// File: rtl/fu_sequencer.sv
// Sequences 8- or 16-bit commands through an external 8-bit function unit.
// A 16-bit command takes a low pass and then a high pass that chains the low-pass carry.
module fu_sequencer #(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [3:0]            cmd_fs,
    input  logic                  cmd_wide,
    input  logic [2*DATA_W-1:0]   cmd_a,
    input  logic [2*DATA_W-1:0]   cmd_b,
    output logic [DATA_W-1:0]     fu_a,
    output logic [DATA_W-1:0]     fu_b,
    output logic [3:0]            fu_fs,
    input  logic [DATA_W-1:0]     fu_op,
    input  logic                  fu_V,
    input  logic                  fu_C,
    input  logic                  fu_N,
    input  logic                  fu_Z,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [2*DATA_W-1:0]   rsp_data,
    output logic                  rsp_V,
    output logic                  rsp_C,
    output logic                  rsp_N,
    output logic                  rsp_Z,
    output logic                  busy
);

    typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [3:0]            r_fs;
    logic                  r_wide;
    logic [2*DATA_W-1:0]   r_a;
    logic [2*DATA_W-1:0]   r_b;
    logic [DATA_W-1:0]     r_res_lo;
    logic                  r_v;
    logic                  r_c;
    logic                  r_n;
    logic                  r_z;
    logic [2*DATA_W-1:0]   r_rsp_data;
    logic                  r_rsp_v;
    logic                  r_rsp_c;
    logic                  r_rsp_n;
    logic                  r_rsp_z;
    logic                  w_two_pass;

    // Shifter ops are inherently single-pass, so the wide flag is ignored for them.
    assign w_two_pass = r_wide && (r_fs[3:2] != 2'b11);

    always_comb begin
        w_next    = r_state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        fu_a      = '0;
        fu_b      = '0;
        fu_fs     = 4'h0;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) w_next = S_LO;
            end
            S_LO: begin
                fu_a   = r_a[DATA_W-1:0];
                fu_b   = r_b[DATA_W-1:0];
                fu_fs  = r_fs;
                w_next = w_two_pass ? S_HI : S_DONE;
            end
            S_HI: begin
                fu_a   = r_a[2*DATA_W-1:DATA_W];
                fu_b   = r_b[2*DATA_W-1:DATA_W];
                fu_fs  = {r_fs[3:1], r_c};
                w_next = S_DONE;
            end
            S_DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_fs       <= 4'h0;
            r_wide     <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_res_lo   <= '0;
            r_v        <= 1'b0;
            r_c        <= 1'b0;
            r_n        <= 1'b0;
            r_z        <= 1'b0;
            r_rsp_data <= '0;
            r_rsp_v    <= 1'b0;
            r_rsp_c    <= 1'b0;
            r_rsp_n    <= 1'b0;
            r_rsp_z    <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_fs   <= cmd_fs;
                        r_wide <= cmd_wide;
                        r_a    <= cmd_a;
                        r_b    <= cmd_b;
                    end
                end
                S_LO: begin
                    r_res_lo <= fu_op;
                    r_v      <= fu_V;
                    r_c      <= fu_C;
                    r_n      <= fu_N;
                    r_z      <= fu_Z;
                    if (!w_two_pass) begin
                        r_rsp_data <= {{DATA_W{1'b0}}, fu_op};
                        r_rsp_v    <= fu_V;
                        r_rsp_c    <= fu_C;
                        r_rsp_n    <= fu_N;
                        r_rsp_z    <= fu_Z;
                    end
                end
                S_HI: begin
                    // Zero only when both bytes are zero; other flags describe the top byte.
                    r_rsp_data <= {fu_op, r_res_lo};
                    r_rsp_v    <= fu_V;
                    r_rsp_c    <= fu_C;
                    r_rsp_n    <= fu_N;
                    r_rsp_z    <= r_z & fu_Z;
                end
                default: ;
            endcase
        end
    end

    assign rsp_data = r_rsp_data;
    assign rsp_V    = r_rsp_v;
    assign rsp_C    = r_rsp_c;
    assign rsp_N    = r_rsp_n;
    assign rsp_Z    = r_rsp_z;
    assign busy     = (r_state != S_IDLE);

endmodule
